// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   - state_e       : controller states (IDLE, CALC, DONE)
//   - DEFAULT_WIDTH : operand width, tied to the project-wide `BUS_WIDTH
// Optional feature macro used by this slice: SERIAL_SUB_OVF_EN (see serial_sub).
// -----------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = `BUS_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_sub_digit.sv
// -----------------------------------------------------------------------------
// sub_digit
// Combinational DIGIT-bit subtractor slice with borrow in and borrow out.
// Ports:
//   a_i      : minuend digit
//   b_i      : subtrahend digit
//   borrow_i : borrow from the previous (less significant) digit
//   diff_o   : a_i - b_i - borrow_i, modulo 2^DIGIT
//   borrow_o : 1 when the digit result went negative
// -----------------------------------------------------------------------------
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             borrow_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             borrow_o
);

  // One extra bit on top: it becomes 1 exactly when the difference underflows,
  // which is the borrow into the next digit.
  logic [DIGIT:0] full;

  assign full = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, borrow_i};
  assign {borrow_o, diff_o} = full;

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Multi-cycle bit-serial subtractor: out = in1 - in2 (mod 2^WIDTH) and a borrow
// flag, processed DIGIT bits per clock, with valid/ready on both sides.
// Parameters:
//   WIDTH : operand/result width (default `BUS_WIDTH)
//   DIGIT : bits per cycle, must divide WIDTH
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   in1, in2            : minuend, subtrahend
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out, borrow         : difference and unsigned borrow (in1 < in2)
//   ovf                 : signed overflow, present only with SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_sub: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             bout_q, bout_d;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_borrow;
  logic [WIDTH-1:0] res_next;
  logic             last_step;

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_sub_digit (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .borrow_i(brw_q),
    .diff_o  (dig_diff),
    .borrow_o(dig_borrow)
  );

  // Digits arrive least significant first, so each new digit enters at the
  // top and the partial result slides down; after STEPS shifts it is aligned.
  // Written with shifts so DIGIT == WIDTH needs no empty slice.
  assign res_next  = (res_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
  assign last_step = (cnt_q == CW'(STEPS - 1));

  // Next-state logic for the controller and datapath registers. The visible
  // result is copied out only on the final digit, so out/borrow never show a
  // partial result and stay put after hand-off.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_next;
        brw_d = dig_borrow;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          out_d   = res_next;
          bout_d  = dig_borrow;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign borrow    = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic sa_q, sb_q, ovf_q;

  // Operand sign bits are kept from accept time because the shift registers
  // have consumed them by the end. Overflow is only possible when the signs
  // differ, and shows as a result sign that disagrees with the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        sa_q <= in1[WIDTH-1];
        sb_q <= in2[WIDTH-1];
      end
      if (state_q == CALC && last_step) begin
        ovf_q <= (sa_q != sb_q) && (res_next[WIDTH-1] != sa_q);
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
// Self-checking bench for serial_sub: a DIGIT=1 instance for most scenarios and
// a DIGIT=4 instance for the wide-digit case. Expected results come from a
// plain-arithmetic reference model. Works with or without SERIAL_SUB_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in1, in2, out;
  logic       borrow;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [7:0] in1_4, in2_4, out4;
  logic       borrow4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf4;
`endif

  int total = 0;
  int bad   = 0;

  serial_sub #(.WIDTH(8), .DIGIT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .borrow   (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  serial_sub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in1      (in1_4),
    .in2      (in2_4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .out      (out4),
    .borrow   (borrow4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {ovf, borrow, out} from integer arithmetic.
  function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b);
    int ua, ub, diff, sa, sb, sd;
    logic [7:0] o;
    logic brw, ov;
    ua   = a;
    ub   = b;
    diff = ua - ub;
    o    = 8'((diff + 256) % 256);
    brw  = (ua < ub);
    sa   = $signed(a);
    sb   = $signed(b);
    sd   = sa - sb;
    ov   = (sd > 127) || (sd < -128);
    return {ov, brw, o};
  endfunction

  // Drives one operand pair into dut (assumed idle) and waits for out_valid.
  // lat counts clock edges including the accept edge; busyReady flags any
  // cycle where in_ready was seen high while the operation was in flight.
  task automatic startAndWait(input logic [7:0] a, input logic [7:0] b,
                              output int lat, output bit busyReady, output bit timedOut);
    @(negedge clk);
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat       = 1;
    busyReady = 1'b0;
    timedOut  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) busyReady = 1'b1;
      if (out_valid) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  // Accepts the pending result; called at a negedge.
  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in1        = '0;
    in2        = '0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    in1_4      = '0;
    in2_4      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    total++;
    if (out !== 8'h00 || borrow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_result: out=%h borrow=%b expected 00 0", out, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ovf: ovf=%b expected 0", ovf);
    end
`endif
  endtask

  task automatic test_basic();
    int lat;
    bit busyReady, timedOut;
    startAndWait(8'd200, 8'd55, lat, busyReady, timedOut);
    total++;
    if (timedOut) begin
      bad++;
      $display("[TB] FAIL basic_timeout: out_valid never rose");
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected 9", lat);
    end
    total++;
    if (busyReady !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_busy_ready: in_ready seen high while busy");
    end
    total++;
    if (out !== 8'd145 || borrow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_result: out=%0d borrow=%b expected 145 0", out, borrow);
    end
    takeResult();
  endtask

  task automatic test_negative();
    logic [7:0] aTab[4] = '{8'd3, 8'd0, 8'h5A, 8'hFF};
    logic [7:0] bTab[4] = '{8'd5, 8'd1, 8'h5A, 8'h00};
    logic [9:0] exp;
    int lat;
    bit busyReady, timedOut;
    for (int k = 0; k < 4; k++) begin
      exp = refModel(aTab[k], bTab[k]);
      startAndWait(aTab[k], bTab[k], lat, busyReady, timedOut);
      total++;
      if (timedOut || out !== exp[7:0] || borrow !== exp[8]) begin
        bad++;
        $display("[TB] FAIL edge_case_%0d: out=%h borrow=%b expected %h %b",
                 k, out, borrow, exp[7:0], exp[8]);
      end
      takeResult();
    end
  endtask

  task automatic test_stall();
    int lat;
    bit busyReady, timedOut;
    startAndWait(8'h64, 8'h14, lat, busyReady, timedOut);
    for (int c = 0; c < 5; c++) begin
      in1      = 8'h11;
      in2      = 8'h22;
      in_valid = 1'b1;
      total++;
      if (timedOut || out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 8'h50 || borrow !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold_%0d: valid=%b ready=%b out=%h borrow=%b expected 1 0 50 0",
                 c, out_valid, in_ready, out, borrow);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_release: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    total++;
    if (out !== 8'h50) begin
      bad++;
      $display("[TB] FAIL stall_out_kept: out=%h expected 50", out);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit busyReady, timedOut;
    @(negedge clk);
    in1      = 8'hAA;
    in2      = 8'h0F;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 8'h00 || borrow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: ready=%b valid=%b out=%h borrow=%b expected 1 0 00 0",
               in_ready, out_valid, out, borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    startAndWait(8'hAA, 8'h0F, lat, busyReady, timedOut);
    total++;
    if (timedOut || out !== 8'h9B || borrow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_rerun: out=%h borrow=%b expected 9b 0", out, borrow);
    end
    takeResult();
  endtask

  task automatic test_digit4();
    logic [7:0] aTab[2] = '{8'h10, 8'h01};
    logic [7:0] bTab[2] = '{8'h01, 8'h10};
    logic [9:0] exp;
    int lat;
    bit seen;
    for (int k = 0; k < 2; k++) begin
      exp = refModel(aTab[k], bTab[k]);
      @(negedge clk);
      total++;
      if (in_ready4 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL digit4_idle_%0d: in_ready=%b expected 1", k, in_ready4);
      end
      in1_4     = aTab[k];
      in2_4     = bTab[k];
      in_valid4 = 1'b1;
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid4) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk);
        lat++;
      end
      total++;
      if (!seen || lat !== 3) begin
        bad++;
        $display("[TB] FAIL digit4_latency_%0d: got %0d seen=%b expected 3", k, lat, seen);
      end
      total++;
      if (out4 !== exp[7:0] || borrow4 !== exp[8]) begin
        bad++;
        $display("[TB] FAIL digit4_result_%0d: out=%h borrow=%b expected %h %b",
                 k, out4, borrow4, exp[7:0], exp[8]);
      end
      out_ready4 = 1'b1;
      @(posedge clk);
      #1 out_ready4 = 1'b0;
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [7:0] aTab[3] = '{8'h80, 8'h7F, 8'h7F};
    logic [7:0] bTab[3] = '{8'h01, 8'h01, 8'hFF};
    logic [9:0] exp;
    int lat;
    bit busyReady, timedOut;
    for (int k = 0; k < 3; k++) begin
      exp = refModel(aTab[k], bTab[k]);
      startAndWait(aTab[k], bTab[k], lat, busyReady, timedOut);
      total++;
      if (timedOut || out !== exp[7:0] || ovf !== exp[9]) begin
        bad++;
        $display("[TB] FAIL ovf_%0d: out=%h ovf=%b expected %h %b", k, out, ovf, exp[7:0], exp[9]);
      end
      takeResult();
    end
  endtask
`endif

  // Random stream with random source gaps and consumer stalls. Handshakes are
  // predicted at the negedge (in_ready/out_valid depend only on state) and
  // take effect at the following posedge.
  task automatic test_back_to_back();
    logic [9:0] expQ[$];
    logic [9:0] exp;
    int sent = 0;
    int got  = 0;
    bit accepted;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in1      = 8'($urandom);
        in2      = 8'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      accepted  = in_valid && in_ready;
      if (accepted) begin
        expQ.push_back(refModel(in1, in2));
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL b2b_extra: result %h with nothing outstanding", out);
        end else begin
          exp = expQ.pop_front();
`ifdef SERIAL_SUB_OVF_EN
          if (out !== exp[7:0] || borrow !== exp[8] || ovf !== exp[9]) begin
            bad++;
            $display("[TB] FAIL b2b_result_%0d: out=%h borrow=%b ovf=%b expected %h %b %b",
                     got, out, borrow, ovf, exp[7:0], exp[8], exp[9]);
          end
`else
          if (out !== exp[7:0] || borrow !== exp[8]) begin
            bad++;
            $display("[TB] FAIL b2b_result_%0d: out=%h borrow=%b expected %h %b",
                     got, out, borrow, exp[7:0], exp[8]);
          end
`endif
        end
      end
      @(posedge clk);
      #1;
      if (accepted) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (sent !== 1000 || got !== 1000 || expQ.size() !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_count: sent=%0d got=%0d pending=%0d expected 1000 1000 0",
               sent, got, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_reset_mid();
    test_digit4();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
